// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the
// instruction-fetch (IF) and data-memory (DM) stages of the MIPS core.
// One access is in flight at a time: IDLE grants, ACCESS strobes the memory
// for one cycle, WAIT counts down MEM_LAT cycles and returns the result.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration between
// IF and DM; without it DM always wins a contested cycle.

module mem_port_arbiter #(
   parameter int MEM_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_valid,
   output logic [31:0] if_rdata,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic        dm_gnt,
   output logic        dm_valid,
   output logic [31:0] dm_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        sel,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2
   } state_t;

   localparam logic OWNER_IF = 1'b0;
   localparam logic OWNER_DM = 1'b1;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        sel_q, sel_d;
   logic        we_q, we_d;
   logic        busy_q, busy_d;
   logic        mem_en_q, mem_en_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        if_valid_q, if_valid_d;
   logic        dm_valid_q, dm_valid_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] dm_rdata_q, dm_rdata_d;
   logic        pick_if, pick_dm;
`ifdef MEM_ARB_RR_EN
   logic        last_owner_q, last_owner_d;
`endif

   // Choose at most one winner, only while idle and out of reset
   always_comb begin
      pick_if = 1'b0;
      pick_dm = 1'b0;
      if ((state_q == ST_IDLE) && !reset) begin
         if (if_req && dm_req) begin
`ifdef MEM_ARB_RR_EN
            pick_dm = (last_owner_q == OWNER_IF);
            pick_if = (last_owner_q == OWNER_DM);
`else
            pick_dm = 1'b1;
            pick_if = 1'b0;
`endif
         end else begin
            pick_dm = dm_req;
            pick_if = if_req;
         end
      end else begin
         pick_if = 1'b0;
         pick_dm = 1'b0;
      end
   end

   assign if_gnt = pick_if;
   assign dm_gnt = pick_dm;

   // Next-state and next-output computation for the access sequencer
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sel_d       = sel_q;
      we_d        = we_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = 32'd0;
      mem_wdata_d = 32'd0;
      if_valid_d  = 1'b0;
      dm_valid_d  = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
`ifdef MEM_ARB_RR_EN
      last_owner_d = last_owner_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // mem_* are registered, so they are loaded on the grant edge
            // and appear exactly during the ACCESS cycle
            if (pick_dm) begin
               state_d     = ST_ACCESS;
               sel_d       = OWNER_DM;
               we_d        = dm_we;
               mem_en_d    = 1'b1;
               mem_we_d    = dm_we;
               mem_addr_d  = dm_addr;
               mem_wdata_d = dm_wdata;
`ifdef MEM_ARB_RR_EN
               last_owner_d = OWNER_DM;
`endif
            end else if (pick_if) begin
               state_d     = ST_ACCESS;
               sel_d       = OWNER_IF;
               we_d        = 1'b0;
               mem_en_d    = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wdata_d = 32'd0;
`ifdef MEM_ARB_RR_EN
               last_owner_d = OWNER_IF;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            state_d = ST_WAIT;
            cnt_d   = 4'(MEM_LAT);
         end
         ST_WAIT: begin
            // A count of 1 marks the cycle the memory data is valid
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = ST_IDLE;
               if (sel_q == OWNER_DM) begin
                  dm_valid_d = 1'b1;
                  if (!we_q) begin
                     dm_rdata_d = mem_rdata;
                  end else begin
                     dm_rdata_d = dm_rdata_q;
                  end
               end else begin
                  if_valid_d = 1'b1;
                  if_rdata_d = mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs; reset abandons any in-flight access
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         sel_q       <= OWNER_IF;
         we_q        <= 1'b0;
         busy_q      <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         if_valid_q  <= 1'b0;
         dm_valid_q  <= 1'b0;
         if_rdata_q  <= 32'd0;
         dm_rdata_q  <= 32'd0;
`ifdef MEM_ARB_RR_EN
         last_owner_q <= OWNER_IF;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         we_q        <= we_d;
         busy_q      <= busy_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_valid_q  <= if_valid_d;
         dm_valid_q  <= dm_valid_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
`ifdef MEM_ARB_RR_EN
         last_owner_q <= last_owner_d;
`endif
      end
   end

   assign if_valid  = if_valid_q;
   assign if_rdata  = if_rdata_q;
   assign dm_valid  = dm_valid_q;
   assign dm_rdata  = dm_rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign sel       = sel_q;
   assign busy      = busy_q;

   mem_port_arbiter_chk #(.MEM_LAT(MEM_LAT)) u_chk (
      .clk   (clk),
      .reset (reset)
   );

endmodule

// Simulation-only parameter sanity checker for mem_port_arbiter.
module mem_port_arbiter_chk #(
   parameter int MEM_LAT = 2
) (
   input logic clk,
   input logic reset
);

   // Flag a memory latency the 4-bit countdown cannot represent
   always @(posedge clk) begin
      if (!reset && ((MEM_LAT < 1) || (MEM_LAT > 15))) begin
         $error("mem_port_arbiter: MEM_LAT=%0d outside 1..15", MEM_LAT);
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported unified memory between the instruction-fetch stage and the data-memory stage of the MIPS core. Accepts one request at a time through a req/gnt handshake, drives the memory with the winning requester's address/data for one cycle, waits a fixed memory latency, and returns read data or a write acknowledge to the owner. The `sel` output steers the 32-bit 2:1 address/data muxes in the datapath (0 = fetch, 1 = data).

## Interface
- `MEM_LAT`, 2, memory read latency in cycles from `mem_en` to valid `mem_rdata`; legal range 1..15.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request; held with `if_addr` until `if_gnt`.
- `if_addr` in 32: fetch address.
- `if_gnt` out 1: fetch request accepted this cycle.
- `if_valid` out 1: one-cycle pulse, `if_rdata` valid.
- `if_rdata` out 32: fetched instruction.
- `dm_req` in 1: data request; held with `dm_we`, `dm_addr` and `dm_wdata` until `dm_gnt`.
- `dm_we` in 1: 1 = write, 0 = read.
- `dm_addr` in 32: data address.
- `dm_wdata` in 32: store data.
- `dm_gnt` out 1: data request accepted this cycle.
- `dm_valid` out 1: one-cycle pulse, read data valid or write done.
- `dm_rdata` out 32: load data.
- `mem_en` out 1: memory access strobe, one cycle per access.
- `mem_we` out 1: memory write enable, qualified by `mem_en`.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, valid `MEM_LAT` cycles after the `mem_en` cycle.
- `sel` out 1: current or last owner (0 = IF, 1 = DM); drives the datapath mux select.
- `busy` out 1: access in progress (state ≠ IDLE).

## Operation
- FSM states:
  - IDLE: arbitrates. If any request is present, asserts the winner's `gnt` combinationally in the same cycle. At the clock edge the arbiter latches the owner, `we`, `addr` and `wdata`, updates `sel`, and moves to ACCESS.
  - ACCESS: drives `mem_en`=1, `mem_we`, `mem_addr` and `mem_wdata` from the latched registers for exactly one cycle. Loads the counter with `MEM_LAT` and moves to WAIT.
  - WAIT: decrements the counter each cycle. On the cycle the counter reaches 1, samples `mem_rdata` into the owner's `rdata` register, sets the owner's `valid` for the next cycle, and returns to IDLE.
- Only one `gnt` is ever asserted in a cycle. No `gnt` is asserted outside IDLE; requests made while busy wait.
- Arbitration default (fixed priority): DM beats IF.
- Writes:
  - `dm_valid` pulses at the same point in the sequence as for a read.
  - `dm_rdata` is not updated.
  - IF requests are always reads; the arbiter ignores the write fields for them.
- `if_rdata` and `dm_rdata` hold their last value between accesses.
- `mem_we`, `mem_addr` and `mem_wdata` are 0 outside ACCESS.
- Reset values: state IDLE; counter 0; `sel`=0; last-owner register = IF. All outputs are 0, including both `rdata` registers.
- Reset asserted mid-access: immediate return to IDLE and all outputs to 0; the in-flight access is abandoned and no `valid` is issued for it after reset deasserts.
- `MEM_LAT` outside 1..15: flagged by a simulation-time `$error`.

## Timing
- Request sampled with `gnt` in cycle T. `mem_en` in T+1. Memory data at `mem_rdata` in T+1+`MEM_LAT`. `valid` and `rdata` in T+2+`MEM_LAT`.
- FSM is in IDLE during the `valid` cycle, so a new `gnt` can coincide with `valid`.
- Throughput: one access every `MEM_LAT`+2 cycles.
- `gnt` is combinational from `req` and state. All other outputs are registered.
- `sel` changes only on the edge that ends a `gnt` cycle. It is therefore stable throughout ACCESS and WAIT.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. When IF and DM request in the same IDLE cycle, the requester that was not the last owner wins. The last-owner register updates on every grant and resets to IF, so the first contested grant after reset goes to DM.
- `MEM_ARB_RR_EN` undefined: fixed priority, DM always wins. The last-owner register is not implemented.

## Test plan
- IF read only, `MEM_LAT`=2, `if_addr`=0x00400000, memory returns 0x8C080004 → `if_gnt` at T, `mem_en`=1 with `mem_addr`=0x00400000 at T+1, `if_valid`=1 with `if_rdata`=0x8C080004 at T+4, `sel`=0 throughout.
- DM write, `dm_addr`=0x10010000, `dm_wdata`=0xDEADBEEF → one cycle of `mem_en`=`mem_we`=1 carrying those values at T+1; `dm_valid` at T+4; `dm_rdata` unchanged; `if_valid` stays 0.
- Both requesting continuously, macro undefined → DM granted at every IDLE; IF never granted until `dm_req` drops. Then IF is granted in the cycle of DM's final `dm_valid`.
- Both requesting continuously, `MEM_ARB_RR_EN` defined → grants alternate DM, IF, DM, IF, starting with DM after reset; `sel` toggles accordingly.
- `if_req` asserted while busy → no `if_gnt` until the cycle DM's `dm_valid` is high; `if_gnt` asserted in that same cycle.
- `reset` pulsed during WAIT → all outputs 0 immediately; no `valid` after release. A fresh IF read afterwards completes with normal T+4 latency.
